// File: rtl/min_uint32_stream_reduce.sv
// min_uint32_stream_reduce: streaming unsigned min reduction; MIN_REDUCE_IDX_EN adds first-minimum index tracking.
module min_uint32_stream_reduce #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [LEN_W-1:0] out_idx,
    output logic             out_empty,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] count, len_r;
    logic empty_r, xfer, last, launch;
    always_comb begin
        in_ready  = state == ACCUM;
        out_valid = state == DONE;
        busy      = state != IDLE;
        out_empty = empty_r;
        out_min   = acc;
        xfer      = in_valid && in_ready;
        last      = count == len_r - 1'b1;
        launch    = state == IDLE && start;
        state_nx  = state == IDLE  ? (start ? (len == '0 ? DONE : ACCUM) : IDLE) :
                    state == ACCUM ? (xfer && last ? DONE : ACCUM) :
                    (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '1;
            count   <= '0;
            len_r   <= '0;
            empty_r <= 1'b0;
        end else if (launch) begin
            acc     <= '1;
            count   <= '0;
            len_r   <= len;
            empty_r <= len == '0;
        end else if (xfer) begin
            if (acc > in_data) acc <= in_data;
            count <= count + 1'b1;
        end else if (out_valid && out_ready) begin
            empty_r <= 1'b0;
        end
    end
`ifdef MIN_REDUCE_IDX_EN
    logic [LEN_W-1:0] idx;
    // strict greater-than keeps the earliest of equal minima
    always_ff @(posedge clk)
        if (!rst_n || launch) idx <= '0;
        else if (xfer && acc > in_data) idx <= count;
    assign out_idx = idx;
`else
    assign out_idx = '0;
`endif
endmodule

// File: doc/min_uint32_stream_reduce.md
Name: min_uint32_stream_reduce

Overview:
- Sequential reduction stage that consumes a stream of unsigned WIDTH-bit operands and produces their minimum.
- Each step applies the same select rule as the combinational 2-input unsigned min benchmark: Y = (acc > x) ? x : acc.
- Sits directly downstream of the operand source and upstream of the result consumer.
- Used as the multi-cycle min-reduction benchmark; the datapath stays simple so synthesis maps the compare/select onto the PIM bit-serial flow.

Parameters:
- WIDTH, 32, operand and result width in bits (unsigned).
- LEN_W, 16, width of the element-count input and of the index counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a reduction; sampled only in IDLE.
- len  input  LEN_W  number of elements to reduce; sampled with start.
- in_valid  input  1  operand valid.
- in_ready  output  1  stage can accept an operand.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_min  output  WIDTH  minimum of the reduced elements.
- out_idx  output  LEN_W  zero-based index of the minimum (see Optional Feature).
- out_empty  output  1  high with out_valid when len was 0.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - in_ready, out_valid, out_empty, busy = 0.
  - out_min = all-ones; out_idx = 0; internal count = 0.
- IDLE:
  - start=1, len>0: latch len; acc = all-ones; count = 0; go to ACCUM next cycle.
  - start=1, len=0: go directly to DONE with out_min = all-ones, out_idx = 0, out_empty = 1.
  - start=0: stay in IDLE.
- ACCUM:
  - in_ready = 1.
  - A transfer occurs when in_valid && in_ready at a clk edge. On each transfer:
    - if acc > in_data (unsigned), then acc = in_data and idx = count;
    - count increments by 1.
  - Tie rule: the earliest occurrence wins, because replacement requires a strict greater-than.
  - On the transfer where count == len-1, go to DONE next cycle.
  - in_ready drops in the same cycle the state leaves ACCUM.
  - Gaps with in_valid=0 are allowed; acc and count hold.
- DONE:
  - out_valid = 1; out_min = acc; out_idx = idx.
  - These outputs hold stable while out_ready = 0.
  - out_valid && out_ready at an edge returns the block to IDLE; out_valid and out_empty clear.
  - out_min and out_idx keep their last values until the next start.
- Latency:
  - Throughput is 1 element per cycle.
  - out_valid asserts exactly 1 cycle after the final input transfer.
  - The earliest next start is the cycle after the out handshake.
- start while busy is ignored; no restart or abort.
- len = 2^LEN_W - 1 is the maximum. count must not wrap before DONE.
- All-ones operands: the result is all-ones with idx 0, since a tie does not replace.
- rst_n low mid-ACCUM or in DONE: all state returns to the reset values on that edge, and the partial result is discarded.
- All registers update only on clk; there are no combinational paths from in_valid to out_valid.

Optional Feature:
- Macro: MIN_REDUCE_IDX_EN.
- Defined: the idx register and count-to-idx capture are implemented, and out_idx reports the index of the first minimum.
- Undefined: the idx register is removed and out_idx is tied to 0. count is still kept for termination.

Test Plan:
- Basic: start with len=4, stream 7, 3, 9, 5 with in_valid always high. Expect out_valid in the cycle after the 4th transfer, with out_min=3, out_idx=1 and out_empty=0.
- Ties and unsigned compare: len=3, stream 0x80000000, 0x00000002, 0x00000002. Expect out_min=2 and out_idx=1, confirming the earliest index wins and 0x80000000 is not treated as negative.
- Empty and backpressure:
  - len=0: expect out_valid the next cycle with out_empty=1 and out_min=0xFFFFFFFF.
  - Hold out_ready=0 for 5 cycles: outputs stay stable, and a start pulsed during that time is ignored.
- Bubbles: len=3, in_valid toggling 1,0,0,1,0,1 with data 10, 4, 6 on the valid cycles. Expect out_min=4 and out_idx=1; in_ready=0 after the 3rd transfer.
- Reset mid-operation: after 2 of 4 transfers, drive rst_n=0 for 1 cycle. Expect in_ready=0, busy=0 and out_min=all-ones. A new start with len=1 and data 42 then yields out_min=42 and out_idx=0.
- Macro off: repeat the Basic test with MIN_REDUCE_IDX_EN undefined. Expect out_min=3 and out_idx=0.
